spi_ram_master: RTL and testbench

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

---
 rtl/spi_ram_master.sv | 140 ++++++++++++++
 tb/tb_spi_ram_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
//==============================================================================
// Module      : spi_ram_master
// Description : SPI master issuing one command frame per request to an SPI RAM
//               slave, with an optional read-back of one data byte.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_ram_master #(
    parameter int MEM_WIDTH = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [MEM_WIDTH-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [MEM_WIDTH-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int c_SR_W = MEM_WIDTH + 2;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_SEL     = 3'd2;
    localparam logic [2:0] c_SHIFT   = 3'd3;
    localparam logic [2:0] c_WAIT_RD = 3'd4;
    localparam logic [2:0] c_RECV    = 3'd5;
    localparam logic [2:0] c_END     = 3'd6;

    localparam logic [3:0] c_SHIFT_LAST = 4'(c_SR_W - 1);
    localparam logic [3:0] c_WAIT_LAST  = 4'(RD_LAT - 1);
    localparam logic [3:0] c_RECV_LAST  = 4'(MEM_WIDTH - 1);

    logic [2:0]           r_state;
    logic [3:0]           r_cnt;
    logic [c_SR_W-1:0]    r_sr;
    logic [MEM_WIDTH-1:0] r_rx;
    logic                 r_rd;
    logic                 r_rsp_valid;
    logic [MEM_WIDTH-1:0] r_rsp_data;
    logic                 r_ss_n;
    logic                 r_mosi;

    logic [2:0]           w_next_state;
    logic [3:0]           w_cnt_next;
    logic                 w_accept;
    logic [MEM_WIDTH-1:0] w_rx_next;

    assign cmd_ready = (r_state == c_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign busy      = (r_state != c_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign w_rx_next = {r_rx[MEM_WIDTH-2:0], MISO};

    // Counted states load their terminal count on entry and advance at zero.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = (r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
        case (r_state)
            c_IDLE:  if (w_accept) w_next_state = c_START;
            c_START: w_next_state = c_SEL;
            c_SEL: begin
                w_next_state = c_SHIFT;
                w_cnt_next   = c_SHIFT_LAST;
            end
            c_SHIFT: begin
                if (r_cnt == 4'd0) begin
                    if (r_rd) begin
                        w_next_state = c_WAIT_RD;
                        w_cnt_next   = c_WAIT_LAST;
                    end else begin
                        w_next_state = c_END;
                    end
                end
            end
            c_WAIT_RD: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = c_RECV;
                    w_cnt_next   = c_RECV_LAST;
                end
            end
            c_RECV:  if (r_cnt == 4'd0) w_next_state = c_END;
            c_END:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // SS_n/MOSI are computed from the next state so the pins line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_sr        <= '0;
            r_rx        <= '0;
            r_rd        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_rsp_valid <= 1'b0;
            r_mosi      <= 1'b0;
            r_ss_n      <= (w_next_state == c_IDLE) || (w_next_state == c_END);
            if (w_accept) begin
                r_sr <= {cmd_op, cmd_data};
                r_rd <= (cmd_op == 2'b11);
            end
            if (r_state == c_RECV) r_rx <= w_rx_next;
            case (w_next_state)
                c_SEL:   r_mosi <= r_sr[c_SR_W-1];
                c_SHIFT: begin
                    r_mosi <= r_sr[c_SR_W-1];
                    r_sr   <= r_sr << 1;
                end
                c_END: begin
                    if (r_state == c_RECV) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rx_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_master.sv
//==============================================================================
// Module      : tb_spi_ram_master
// Description : Directed bench for spi_ram_master with an SPI RAM slave model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_ram_master;

    localparam int MW     = 8;
    localparam int RD_LAT = 2;
    localparam int c_FW   = MW + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [MW-1:0] cmd_data;
    logic          rsp_valid;
    logic [MW-1:0] rsp_data;
    logic          busy;
    logic          SS_n;
    logic          MOSI;
    logic          MISO = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic aborted = 1'b0;

    logic [c_FW-1:0] frame_q[$];
    logic [MW-1:0]   rsp_q[$];

    spi_ram_master #(.MEM_WIDTH(MW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [1:0] op, input logic [MW-1:0] d,
                        input logic [MW-1:0] exp_rsp, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        frame_q.push_back({op[1], op, d});
        if (op == 2'b11) rsp_q.push_back(exp_rsp);
        @(posedge clk);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int len);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        len = n - 1;
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
            else check("rsp_data", rsp_data, rsp_q.pop_front());
        end
    end

    // SPI RAM slave: decodes frames, checks them against the frame queue, serves reads
    int            s_b = 0;
    int            s_exp_len = 0;
    logic [c_FW-1:0] s_sh = '0;
    logic [1:0]    s_op = 2'b00;
    logic [MW-1:0] s_addr = '0;
    logic [MW-1:0] s_rd = '0;
    logic [MW-1:0] s_mem [256];

    always @(negedge clk) begin
        if (rst === 1'b1 || SS_n !== 1'b0) begin
            if (s_b != 0 && !aborted) check("ss_low_cycles", s_b, s_exp_len);
            s_b  = 0;
            MISO = 1'b0;
        end else begin
            if (s_b == 0) check("start_mosi", MOSI, 0);
            else if (s_b <= 11) s_sh = {s_sh[c_FW-2:0], MOSI};
            if (s_b == 11) begin
                if (frame_q.size() == 0) check("frame_pending", frame_q.size(), 1);
                else check("frame_bits", s_sh, frame_q.pop_front());
                s_op = s_sh[MW+1:MW];
                case (s_op)
                    2'b00, 2'b10: s_addr = s_sh[MW-1:0];
                    2'b01:        s_mem[s_addr] = s_sh[MW-1:0];
                    default:      s_rd = s_mem[s_addr];
                endcase
                s_exp_len = (s_op == 2'b11) ? 12 + RD_LAT + MW : 12;
            end
            if (s_op == 2'b11 && s_b >= 12 + RD_LAT && s_b < 12 + RD_LAT + MW)
                MISO = s_rd[MW-1-(s_b-12-RD_LAT)];
            else
                MISO = 1'b0;
            s_b++;
        end
    end

    initial begin
        int a1, a2, len, n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
        @(negedge clk);
        check("rst_ss_n", SS_n, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // write-address frame
        send(2'b00, 8'h5A, '0, a1);
        wait_idle(len);
        check("len_wr", len, 13);

        // back-to-back write-data then read-address
        send(2'b01, 8'hC3, '0, a1);
        send(2'b10, 8'h12, '0, a2);
        check("b2b_gap", a2 - a1, 14);
        wait_idle(len);

        // read returning 0xA5
        send(2'b00, 8'h33, '0, a1); wait_idle(len);
        send(2'b01, 8'hA5, '0, a1); wait_idle(len);
        send(2'b10, 8'h33, '0, a1); wait_idle(len);
        send(2'b11, 8'h00, 8'hA5, a1);
        wait_idle(len);
        check("len_rd", len, 23 - 2 + RD_LAT);
        check("rsp_hold_a5", rsp_data, 8'hA5);
        send(2'b00, 8'h44, '0, a1); wait_idle(len);
        check("rsp_hold_after_wr", rsp_data, 8'hA5);

        // end-to-end RAM write/read
        send(2'b00, 8'h10, '0, a1); wait_idle(len);
        send(2'b01, 8'h77, '0, a1); wait_idle(len);
        send(2'b10, 8'h10, '0, a1); wait_idle(len);
        send(2'b11, 8'h00, 8'h77, a1); wait_idle(len);
        check("e2e_rsp", rsp_data, 8'h77);
        send(2'b10, 8'h33, '0, a1); wait_idle(len);
        send(2'b11, 8'h00, 8'hA5, a1); wait_idle(len);
        check("e2e_rsp2", rsp_data, 8'hA5);

        // cmd_valid held high with changing data while busy
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h3C;
        frame_q.push_back({1'b0, 2'b00, 8'h3C});
        @(posedge clk); #1 a1 = cyc;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (cmd_ready || n >= 100) break;
            cmd_data = MW'($urandom);
        end
        check("held_ready", cmd_ready, 1);
        cmd_data = 8'h81;
        frame_q.push_back({1'b0, 2'b00, 8'h81});
        @(posedge clk); #1 a2 = cyc;
        cmd_valid = 1'b0;
        check("held_gap", a2 - a1, 14);
        wait_idle(len);

        // reset during WAIT_RD of a read frame
        send(2'b11, 8'h00, 8'h00, a1);
        repeat (13) @(negedge clk);
        check("abort_busy_before", busy, 1);
        aborted = 1'b1;
        rst = 1'b1;
        rsp_q.delete();
        @(negedge clk);
        check("abort_ss_n", SS_n, 1);
        check("abort_busy", busy, 0);
        check("abort_rsp_data", rsp_data, 0);
        check("abort_ready_in_rst", cmd_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", cmd_ready, 1);
        repeat (30) @(negedge clk);
        aborted = 1'b0;
        check("abort_rsp_data_late", rsp_data, 0);

        check("rsp_q_drained", rsp_q.size(), 0);
        check("frame_q_drained", frame_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
